// File: rtl/auto_nav_ctrl.sv
// auto_nav_ctrl: right-hand wall-following Moore FSM driving timed motion and barrier commands
module auto_nav_ctrl #(
  parameter int unsigned TURN_CYCLES   = 50_000_000,
  parameter int unsigned MOVE_CYCLES   = 30_000_000,
  parameter int unsigned SETTLE_CYCLES = 10_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       front_detector,
  input  logic       back_detector,
  input  logic       left_detector,
  input  logic       right_detector,
  output logic       move_forward_signal,
  output logic       move_backward_signal,
  output logic       turn_left_signal,
  output logic       turn_right_signal,
  output logic       place_barrier_signal,
  output logic       destroy_barrier_signal,
  output logic [2:0] state_out,
  output logic       busy
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECIDE    = 3'd1,
    TURN_R    = 3'd2,
    TURN_L    = 3'd3,
    TURN_BACK = 3'd4,
    FORWARD   = 3'd5,
    SETTLE    = 3'd6
  } state_t;
  localparam logic [31:0] TURN_LD   = 32'(TURN_CYCLES - 1);
  localparam logic [31:0] BACK_LD   = 32'(2 * TURN_CYCLES - 1);
  localparam logic [31:0] MOVE_LD   = 32'(MOVE_CYCLES - 1);
  localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYCLES - 1);
  state_t      state, state_d;
  logic [31:0] timer, timer_d, load;
  logic        front_q, back_q, left_q, right_q;
  logic        unused_back;
  assign unused_back            = back_q;
  assign state_out              = state;
  assign move_backward_signal   = 1'b0;
  assign destroy_barrier_signal = 1'b0;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:                      state_d = DECIDE;
      DECIDE:                    state_d = !right_q ? TURN_R : !front_q ? FORWARD : !left_q ? TURN_L : TURN_BACK;
      TURN_R, TURN_L, TURN_BACK: state_d = timer == 32'd0 ? FORWARD : state;
      FORWARD:                   state_d = (front_q || timer == 32'd0) ? SETTLE : FORWARD;
      SETTLE:                    state_d = timer == 32'd0 ? DECIDE : SETTLE;
      default:                   state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
    load = (state_d == TURN_R || state_d == TURN_L) ? TURN_LD :
           state_d == TURN_BACK ? BACK_LD :
           state_d == FORWARD   ? MOVE_LD :
           state_d == SETTLE    ? SETTLE_LD : 32'd0;
    timer_d = state_d != state ? load : timer != 32'd0 ? timer - 32'd1 : 32'd0;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state                <= IDLE;
      timer                <= '0;
      {front_q, back_q, left_q, right_q} <= '0;
      move_forward_signal  <= 1'b0;
      turn_left_signal     <= 1'b0;
      turn_right_signal    <= 1'b0;
      place_barrier_signal <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_d;
      timer                <= timer_d;
      {front_q, back_q, left_q, right_q} <= {front_detector, back_detector, left_detector, right_detector};
      move_forward_signal  <= state_d == FORWARD;
      turn_left_signal     <= state_d == TURN_L || state_d == TURN_BACK;
      turn_right_signal    <= state_d == TURN_R;
      place_barrier_signal <= state_d == TURN_BACK && state != TURN_BACK;
      busy                 <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_auto_nav_ctrl.sv
// tb_auto_nav_ctrl: vector-table and randomized model-based checks of auto_nav_ctrl
module tb_auto_nav_ctrl;
  localparam int T = 4;
  localparam int M = 8;
  localparam int S = 2;
  localparam logic [5:0] MF = 6'b100000;
  localparam logic [5:0] TL = 6'b001000;
  localparam logic [5:0] TR = 6'b000100;
  localparam logic [5:0] PB = 6'b000010;
  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] det;
    int         n;
    logic [2:0] st;
    logic [5:0] o;
  } vec_t;
  typedef struct packed {
    logic [2:0] st;
    logic [5:0] o;
  } step_t;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic front_detector = 1'b0, back_detector = 1'b0, left_detector = 1'b0, right_detector = 1'b0;
  logic mf, mb, tl, tr, pb, db, busy;
  logic [2:0] state_out;
  int errors = 0;
  int checks = 0;
  vec_t tbl[$];
  step_t plan[$];
  step_t cur;
  logic [3:0] dq;
  auto_nav_ctrl #(.TURN_CYCLES(T), .MOVE_CYCLES(M), .SETTLE_CYCLES(S)) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable),
    .front_detector(front_detector), .back_detector(back_detector),
    .left_detector(left_detector), .right_detector(right_detector),
    .move_forward_signal(mf), .move_backward_signal(mb),
    .turn_left_signal(tl), .turn_right_signal(tr),
    .place_barrier_signal(pb), .destroy_barrier_signal(db),
    .state_out(state_out), .busy(busy)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(string name, logic [2:0] st, logic [5:0] o);
    logic [9:0] act, exp;
    act = {state_out, busy, mf, mb, tl, tr, pb, db};
    exp = {st, st != 3'd0, o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got st=%0d busy=%b o=%b, want st=%0d busy=%b o=%b",
               name, $time, act[9:7], act[6], act[5:0], exp[9:7], exp[6], exp[5:0]);
    end
    checks++;
    if ($countones({mf, mb, tl, tr}) > 1) begin
      errors++;
      $display("FAIL %s one_hot t=%0t: motion=%b, want at most one set", name, $time, {mf, mb, tl, tr});
    end
  endtask
  task automatic push_n(int n, logic [2:0] st, logic [5:0] o);
    for (int i = 0; i < n; i++) plan.push_back({st, o});
  endtask
  task automatic model_step();
    if (rst) begin
      plan.delete();
      cur = {3'd0, 6'd0};
      dq = 4'd0;
    end else begin
      if (!enable) begin
        plan.delete();
        cur = {3'd0, 6'd0};
      end else if (cur.st == 3'd0) begin
        cur = {3'd1, 6'd0};
      end else begin
        if (cur.st == 3'd1) begin
          if (!dq[0]) push_n(T, 3'd2, TR);
          else if (dq[3]) begin
            if (!dq[1]) push_n(T, 3'd3, TL);
            else begin
              push_n(1, 3'd4, TL | PB);
              push_n(2 * T - 1, 3'd4, TL);
            end
          end
          push_n(M, 3'd5, MF);
          push_n(S, 3'd6, 6'd0);
        end else if (cur.st == 3'd5 && dq[3]) begin
          while (plan.size() > 0 && plan[0].st == 3'd5) void'(plan.pop_front());
        end
        if (plan.size() > 0) cur = plan.pop_front();
        else cur = {3'd1, 6'd0};
      end
      dq = {front_detector, back_detector, left_detector, right_detector};
    end
  endtask
  initial begin
    logic [3:0] det;
    tbl.push_back(vec_t'{1'b1, 1'b0, 4'b1000, 1, 3'd0, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b0, 4'b1000, 1, 3'd0, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b1000, 1, 3'd1, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4, 3'd2, TR});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 8, 3'd5, MF});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 2, 3'd6, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 1, 3'd1, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0001, 8, 3'd5, MF});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b1011, 2, 3'd6, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b1011, 1, 3'd1, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1, 3'd4, TL | PB});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 7, 3'd4, TL});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 3, 3'd5, MF});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b1000, 1, 3'd5, MF});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b1000, 1, 3'd6, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1, 3'd6, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1, 3'd1, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 2, 3'd2, TR});
    tbl.push_back(vec_t'{1'b0, 1'b0, 4'b0000, 1, 3'd0, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1, 3'd1, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4, 3'd2, TR});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 2, 3'd5, MF});
    tbl.push_back(vec_t'{1'b1, 1'b1, 4'b0000, 1, 3'd0, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1, 3'd1, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1, 3'd2, TR});
    tbl.push_back(vec_t'{1'b0, 1'b0, 4'b1001, 1, 3'd0, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b1001, 1, 3'd1, 6'd0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 4, 3'd3, TL});
    tbl.push_back(vec_t'{1'b0, 1'b1, 4'b0000, 1, 3'd5, MF});
    @(negedge sys_clk);
    foreach (tbl[i]) begin
      repeat (tbl[i].n) begin
        rst = tbl[i].rst;
        enable = tbl[i].en;
        {front_detector, back_detector, left_detector, right_detector} = tbl[i].det;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check($sformatf("vec%0d", i), tbl[i].st, tbl[i].o);
      end
    end
    det = 4'd0;
    for (int k = 0; k < 4000; k++) begin
      rst = (k == 0) || ($urandom_range(0, 299) == 0);
      enable = $urandom_range(0, 99) != 0;
      if ($urandom_range(0, 5) == 0) det = 4'($urandom);
      {front_detector, back_detector, left_detector, right_detector} = det;
      @(posedge sys_clk);
      model_step();
      @(negedge sys_clk);
      check("rand", cur.st, cur.o);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
